// File: rtl/mult_div_seq.sv
// mult_div_seq
// Multicycle sequencer for the signed MULT/DIV resource feeding HI/LO.
// A start pulse in IDLE captures operand magnitudes and signs. RUN performs
// WIDTH iterations of shift-add multiply or restoring divide, one per cycle.
// FIX applies sign correction and writes hi_out/lo_out. DONE emits a
// one-cycle done pulse. A DIV with b_in == 0 goes straight from IDLE to DONE,
// raises div_zero together with done, and leaves HI/LO untouched.
//
// Optional build macro: MD_ZERO_SKIP_EN
//   When defined, a non-div-zero start with a_in == 0 or b_in == 0 skips RUN
//   (IDLE -> FIX) and produces hi_out = lo_out = 0 with done in cycle N+2.
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous active-high reset (aborts any operation)
//   start     in   request pulse, sampled only in IDLE
//   op        in   0 = MULT, 1 = DIV
//   a_in      in   multiplicand / dividend (two's complement)
//   b_in      in   multiplier / divisor (two's complement)
//   busy      out  high while an operation is in flight
//   done      out  one-cycle completion pulse
//   div_zero  out  one-cycle pulse with done for DIV by zero
//   hi_out    out  HI result (product upper half / remainder)
//   lo_out    out  LO result (product lower half / quotient)
module mult_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int               CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  // Magnitude of a two's complement value. The most negative value maps to
  // the unsigned 2^(WIDTH-1), which the datapath handles as an ordinary
  // unsigned magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    return (v < 0) ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v,
                                             input logic n);
    return n ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_dw(input logic [2*WIDTH-1:0] v,
                                                input logic n);
    return n ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  logic [1:0]         state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // MULT: 2*WIDTH product/multiplier register.
  // DIV:  {remainder, quotient} register, dividend initially in the low half.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // MULT: multiplicand magnitude. DIV: divisor magnitude.
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               op_q, op_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;

  // Single iteration datapath
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   div_diff;
  logic               div_fits;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Carry out of the upper-half add is kept and shifted back in.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_fits = (rem_sh >= {1'b0, opnd_q});
  // Only used when the trial subtract does not borrow, so the low bits suffice.
  assign div_diff = rem_sh[WIDTH-1:0] - opnd_q;

  assign prod_fix = neg_dw(acc_q, sa_q ^ sb_q);
  assign quo_fix  = neg_w(acc_q[WIDTH-1:0], sa_q ^ sb_q);
  assign rem_fix  = neg_w(acc_q[2*WIDTH-1:WIDTH], sa_q);

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op && (b_in == '0)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            dz_d    = 1'b1;
          end else begin
            op_d   = op;
            sa_d   = a_in[WIDTH-1];
            sb_d   = b_in[WIDTH-1];
            cnt_d  = '0;
            busy_d = 1'b1;
            opnd_d = op ? mag(b_in) : mag(a_in);
            acc_d  = {{WIDTH{1'b0}}, (op ? mag(a_in) : mag(b_in))};
`ifdef MD_ZERO_SKIP_EN
            if ((a_in == '0) || (b_in == '0)) begin
              acc_d   = '0;
              state_d = S_FIX;
            end else begin
              state_d = S_RUN;
            end
`else
            state_d = S_RUN;
`endif
          end
        end
      end

      S_RUN: begin
        if (op_q) begin
          if (div_fits) begin
            acc_d = {div_diff, acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          if (acc_q[0]) begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end else begin
            acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
          end
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (op_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      op_q    <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// Testbench for mult_div_seq: transaction-level model (signed 64-bit
// arithmetic plus a latency counter) checked every cycle, together with
// directed vectors carrying hand-computed results and latencies.
module tb_mult_div_seq;

  localparam int W = 32;

`ifdef MD_ZERO_SKIP_EN
  localparam int ZERO_LAT = 2;
`else
  localparam int ZERO_LAT = W + 2;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         op    = 1'b0;
  logic [W-1:0] a_in  = '0;
  logic [W-1:0] b_in  = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi_out, lo_out;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  mult_div_seq #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a_in     (a_in),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: t counts cycles since acceptance (0 = idle), L is the
  // total latency to the done cycle; results appear when t reaches L.
  int           t = 0;
  int           L = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic [W-1:0] p_hi = '0, p_lo = '0;
  bit           p_dz = 1'b0;

  always @(posedge clock or posedge reset) begin
    longint sa, sb, pr, q, r;
    if (reset) begin
      t = 0; m_hi = '0; m_lo = '0; p_dz = 1'b0;
    end else if (t == 0) begin
      if (start) begin
        sa = longint'($signed(a_in));
        sb = longint'($signed(b_in));
        p_dz = 1'b0;
        if (op && sb == 0) begin
          p_dz = 1'b1; L = 1;
        end else begin
          if (op) begin
            q = sa / sb; r = sa % sb;
            p_lo = q[W-1:0]; p_hi = r[W-1:0];
          end else begin
            pr = sa * sb;
            p_lo = pr[W-1:0]; p_hi = pr[2*W-1:W];
          end
          L = (sa == 0 || sb == 0) ? ZERO_LAT : W + 2;
        end
        t = 1;
        if (t == L && !p_dz) begin m_hi = p_hi; m_lo = p_lo; end
      end
    end else if (t == L) begin
      t = 0;
    end else begin
      t++;
      if (t == L && !p_dz) begin m_hi = p_hi; m_lo = p_lo; end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("model_busy", {63'd0, busy}, {63'd0, (t >= 1 && t <= L - 1)});
      check("model_done", {63'd0, done}, {63'd0, (t != 0 && t == L)});
      check("model_div_zero", {63'd0, div_zero}, {63'd0, (t != 0 && t == L && p_dz)});
      check("model_hi", {32'd0, hi_out}, {32'd0, m_hi});
      check("model_lo", {32'd0, lo_out}, {32'd0, m_lo});
    end
  end

  // Issue one operation and wait for done. inj > 0 pulses an extra DIV-by-zero
  // start at that cycle, which must be ignored.
  task automatic do_op(input string nm, input logic o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int exp_lat,
                       input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                       input logic exp_dz, input int inj);
    int k, nbusy, ndone;
    @(posedge clock); #2;
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(posedge clock); #2;
    start = 1'b0; a_in = $urandom; b_in = $urandom; op = $urandom_range(0, 1);
    k = 1; nbusy = 0;
    while (!done && k < 100) begin
      if (busy) nbusy++;
      if (k == inj) begin start = 1'b1; op = 1'b1; a_in = 32'd5; b_in = '0; end
      else start = 1'b0;
      @(posedge clock); #2;
      k++;
    end
    start = 1'b0;
    check({nm, "_latency"}, 64'(k), 64'(exp_lat));
    check({nm, "_busy_cycles"}, 64'(nbusy), 64'(exp_lat - 1));
    check({nm, "_div_zero"}, {63'd0, div_zero}, {63'd0, exp_dz});
    check({nm, "_hi"}, {32'd0, hi_out}, {32'd0, exp_hi});
    check({nm, "_lo"}, {32'd0, lo_out}, {32'd0, exp_lo});
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #2;
      if (done) ndone++;
    end
    check({nm, "_single_done"}, 64'(ndone), 64'd0);
  endtask

  task automatic abort_op();
    int ndone;
    @(posedge clock); #2;
    start = 1'b1; op = 1'b0; a_in = 32'd123; b_in = 32'd456;
    @(posedge clock); #2;
    start = 1'b0;
    for (int k = 1; k < 20; k++) begin @(posedge clock); #2; end
    check("abort_busy_before", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_hi", {32'd0, hi_out}, 64'd0);
    check("abort_lo", {32'd0, lo_out}, 64'd0);
    @(posedge clock); #2;
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #2;
      if (done) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #2;
    chk_en = 1'b1;
    reset  = 1'b0;
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_div_zero", {63'd0, div_zero}, 64'd0);
    check("reset_hi", {32'd0, hi_out}, 64'd0);
    check("reset_lo", {32'd0, lo_out}, 64'd0);

    do_op("mul_7_m3",   1'b0, 32'h00000007, 32'hFFFFFFFD, 34, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 0);
    do_op("mul_min_min",1'b0, 32'h80000000, 32'h80000000, 34, 32'h40000000, 32'h00000000, 1'b0, 0);
    do_op("div_100_7",  1'b1, 32'd100,      32'd7,        34, 32'd2,        32'd14,       1'b0, 0);
    do_op("div_m7_2",   1'b1, 32'hFFFFFFF9, 32'd2,        34, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0);
    do_op("div_7_m2",   1'b1, 32'd7,        32'hFFFFFFFE, 34, 32'd1,        32'hFFFFFFFD, 1'b0, 0);
    do_op("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 34, 32'h00000000, 32'h80000000, 1'b0, 0);
    do_op("div_5_2",    1'b1, 32'd5,        32'd2,        34, 32'd1,        32'd2,        1'b0, 0);
    do_op("div_5_0",    1'b1, 32'd5,        32'd0,        1,  32'd1,        32'd2,        1'b1, 0);
    do_op("mul_3_4_inj",1'b0, 32'd3,        32'd4,        34, 32'd0,        32'd12,       1'b0, 10);
    abort_op();
    do_op("mul_m5_6",   1'b0, 32'hFFFFFFFB, 32'd6,        34, 32'hFFFFFFFF, 32'hFFFFFFE2, 1'b0, 0);
    do_op("mul_0_1234", 1'b0, 32'd0,        32'h1234,     ZERO_LAT, 32'd0,  32'd0,        1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_seq.md
Name: mult_div_seq

Overview:
Multicycle sequencer for the signed MULT/DIV resource. It sits behind the MDSrcA/MDSrcB operand muxes and feeds the HI/LO registers. `unid_controle` pulses `start` with an operation code, then holds in a wait state until `done`. Internally the block runs an iterative shift-add multiply or restoring divide on operand magnitudes, applies sign correction, and flags divide-by-zero for the exception path (ConstDiv0 vector).

Parameters:
WIDTH, 32, operand width; also the iteration count.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request pulse; sampled only in IDLE
op  in  1  0 = MULT, 1 = DIV
a_in  in  WIDTH  MDSrcA operand (multiplicand / dividend), two's complement
b_in  in  WIDTH  MDSrcB operand (multiplier / divisor), two's complement
busy  out  1  high while an operation is in flight
done  out  1  one-cycle completion pulse
div_zero  out  1  one-cycle pulse, coincident with done, when DIV has b_in == 0
hi_out  out  WIDTH  HI result, registered
lo_out  out  WIDTH  LO result, registered

Behaviour:
- Reset (asynchronous, active-high): state = IDLE; busy, done, div_zero, hi_out, lo_out, counter and all work registers = 0. Reset mid-operation aborts the operation; no done is produced.
- States: IDLE, RUN, FIX, DONE.
- IDLE, start = 1, no divide-by-zero:
  - capture |a_in|, |b_in|, sign bits, op; counter = 0.
  - next state RUN; busy = 1 from the next cycle.
- IDLE, start = 1, op = 1, b_in == 0:
  - next state DONE with done = 1 and div_zero = 1.
  - hi_out / lo_out keep their previous values; RUN is never entered.
- RUN, one iteration per cycle, WIDTH cycles; after the WIDTH-th iteration go to FIX.
  - MULT: 2·WIDTH-bit product register; if the product's LSB multiplier bit is set, add the multiplicand to the upper half; then shift right 1.
  - DIV: restoring division; shift {remainder, quotient} left 1; trial-subtract the divisor magnitude; on no borrow keep the difference and set quotient LSB = 1.
- FIX, 1 cycle: negate results as needed and write hi_out / lo_out, then go to DONE.
  - MULT: negate the 2·WIDTH product if sign_a ^ sign_b; hi_out = upper half, lo_out = lower half.
  - DIV: lo_out = quotient, negated if sign_a ^ sign_b (truncation toward zero).
  - DIV: hi_out = remainder, negated if sign_a (remainder takes the sign of the dividend).
- DONE, 1 cycle: done = 1, busy = 0; go to IDLE unconditionally.
- Latency: start sampled on edge N gives done high in cycle N+WIDTH+2; divide-by-zero gives done in cycle N+1.
- start outside IDLE (RUN, FIX, DONE) is ignored and not queued. Operand inputs are don't-care after the capture edge.
- Edge cases:
  - |−2^(WIDTH−1)| is handled as unsigned 2^(WIDTH−1) in the magnitude datapath.
  - 0x80000000 / −1 gives lo_out = 0x80000000, hi_out = 0, no flag.
- hi_out / lo_out change only in FIX and hold between operations.

Optional Feature:
MD_ZERO_SKIP_EN
- Defined: in IDLE, a start with no divide-by-zero and a_in == 0 or b_in == 0 bypasses RUN (IDLE -> FIX). Result hi_out = lo_out = 0; done arrives in cycle N+2.
- Undefined: every non-div-zero operation takes the full WIDTH+2 latency.

Test Plan:
- MULT 7 × −3 (0x00000007, 0xFFFFFFFD) -> done at start+34; hi_out = 0xFFFFFFFF, lo_out = 0xFFFFFFEB; busy high for cycles +1..+33.
- MULT 0x80000000 × 0x80000000 -> hi_out = 0x40000000, lo_out = 0x00000000.
- DIV 100 / 7 -> lo_out = 14, hi_out = 2. DIV −7 / 2 -> lo_out = 0xFFFFFFFD, hi_out = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo_out = 0x80000000, hi_out = 0.
- Prior result hi/lo = 0x1/0x2, then DIV 5 / 0 -> done and div_zero pulse at start+1; hi_out = 0x1, lo_out = 0x2 unchanged; busy never rises.
- Start MULT 3 × 4; pulse start with op = DIV at cycle +10 -> ignored; single done at +34 with lo_out = 12. Assert reset at cycle +20 of a second operation -> all outputs 0 immediately, no done, next start works normally.
- With MD_ZERO_SKIP_EN: MULT 0 × 0x1234 -> done at start+2, hi/lo = 0. Without the macro: done at start+34.
